// File: rtl/punch_card_reader_if.sv
// Card stream handshake between the deck reader (master) and the drum/adder logic (slave).
interface punch_card_reader_if #(
    parameter int CW     = 20,
    parameter int ADDR_W = 4
);
    logic              card_valid;
    logic              card_ready;
    logic [CW-1:0]     card_data;
    logic [ADDR_W-1:0] card_idx;
    logic              card_last;

    modport master (
        output card_valid,
        output card_data,
        output card_idx,
        output card_last,
        input  card_ready
    );

    modport slave (
        input  card_valid,
        input  card_data,
        input  card_idx,
        input  card_last,
        output card_ready
    );
endinterface

// File: rtl/punch_card_reader.sv
// Writable punch-card deck store: NUM_DECKS decks of DEPTH BCD cards (4'hF = unpunched),
// streaming one selected deck card-by-card to the drum/adder logic over valid/ready.
module punch_card_reader #(
    parameter int DIGITS    = 5,
    parameter int DEPTH     = 15,
    parameter int NUM_DECKS = 8,
    parameter int DECK_W    = (NUM_DECKS > 1) ? $clog2(NUM_DECKS) : 1,
    parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DECK_W-1:0]     wr_deck,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic                  start,
    input  logic [DECK_W-1:0]     deck_sel,
    input  logic                  stop_on_blank,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    punch_card_reader_if.master   card
);
    localparam int CW      = 4 * DIGITS;
    localparam int WORDS   = NUM_DECKS * DEPTH;
    localparam int MEM_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WIDE_W  = DECK_W + ADDR_W;
    localparam int DECK_WP = DECK_W + 1;
    localparam int ADDR_WP = ADDR_W + 1;

    localparam logic [CW-1:0]      BLANK_CARD = {CW{1'b1}};
    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]  FIRST_IDX  = {ADDR_W{1'b0}};
    localparam logic [DECK_W:0]    DECK_LIMIT = DECK_WP'(NUM_DECKS);
    localparam logic [ADDR_W:0]    ADDR_LIMIT = ADDR_WP'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_BLANK   = 2'd3
    } state_t;

    function automatic logic [MEM_W-1:0] word_addr(input logic [DECK_W-1:0] deck,
                                                   input logic [ADDR_W-1:0] idx);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(deck) * WIDE_W'(DEPTH) + WIDE_W'(idx);
        return MEM_W'(wide);
    endfunction

    // Power-up contents are all unpunched; reset deliberately leaves the decks alone.
    logic [CW-1:0] mem_r [WORDS] = '{default: BLANK_CARD};

    state_t            state_r;
    logic [DECK_W-1:0] deck_r;
    logic              stop_r;
    logic [ADDR_W-1:0] idx_r;
    logic [CW-1:0]     data_r;
    logic              valid_r;
    logic              last_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              wr_hit_s;
    logic [MEM_W-1:0]  wr_word_s;
    logic [MEM_W-1:0]  rd_word_addr_s;
    logic [CW-1:0]     rd_word_s;
    logic              deck_ok_s;
    logic              blank_s;

    assign wr_hit_s       = wr_en && ({1'b0, wr_deck} < DECK_LIMIT) && ({1'b0, wr_addr} < ADDR_LIMIT);
    assign wr_word_s      = word_addr(wr_deck, wr_addr);
    assign rd_word_addr_s = word_addr(deck_r, idx_r);
    assign rd_word_s      = mem_r[rd_word_addr_s];
    assign deck_ok_s      = ({1'b0, deck_sel} < DECK_LIMIT);
    assign blank_s        = stop_r && (rd_word_s == BLANK_CARD);

    // Card store write port; a fetch on the same edge still captures the previous word.
    always_ff @(posedge clk) begin
        if (wr_hit_s) begin
            mem_r[wr_word_s] <= wr_data;
        end
    end

    // Sequencer: start -> fetch -> present (or blank) -> next card / finish.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            deck_r  <= {DECK_W{1'b0}};
            stop_r  <= 1'b0;
            idx_r   <= FIRST_IDX;
            data_r  <= BLANK_CARD;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (abort && (state_r != ST_IDLE)) begin
                // An aborted card counts as not consumed even if ready was high.
                state_r <= ST_IDLE;
                valid_r <= 1'b0;
                last_r  <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start && deck_ok_s) begin
                            deck_r  <= deck_sel;
                            stop_r  <= stop_on_blank;
                            idx_r   <= FIRST_IDX;
                            busy_r  <= 1'b1;
                            state_r <= ST_FETCH;
                        end else if (start) begin
                            err_r <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        data_r  <= rd_word_s;
                        valid_r <= !blank_s;
                        last_r  <= !blank_s && (idx_r == LAST_IDX);
                        state_r <= ST_PRESENT;
                    end
                    ST_PRESENT: begin
                        if (!valid_r) begin
                            done_r  <= 1'b1;
                            state_r <= ST_BLANK;
                        end else if (card.card_ready) begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            if (idx_r == LAST_IDX) begin
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= ST_IDLE;
                            end else begin
                                idx_r   <= idx_r + ADDR_W'(1);
                                state_r <= ST_FETCH;
                            end
                        end
                    end
                    ST_BLANK: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign card.card_valid = valid_r;
    assign card.card_data  = data_r;
    assign card.card_idx   = idx_r;
    assign card.card_last  = last_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
endmodule

// File: doc/punch_card_reader.md
# punch_card_reader

Parametrised punch-card deck store and sequencer for the base-conversion datapath. It holds NUM_DECKS loadable decks: equation decks and power-of-ten mask decks, up to DEPTH cards each, every card DIGITS BCD digits wide with 4'hF meaning "unpunched". On command it streams one selected deck card-by-card to the downstream drum/adder logic over a valid/ready handshake. It replaces fixed combinational card ROMs with a writable, handshaked, end-of-deck-aware reader.

## Interface
Parameters:
- DIGITS, 5, digits per card; card width CW = 4*DIGITS
- DEPTH, 15, cards per deck
- NUM_DECKS, 8, number of decks (equation and mask decks share one address space)
- DECK_W, $clog2(NUM_DECKS) (min 1), deck select width
- ADDR_W, $clog2(DEPTH) (min 1), card index width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_en  in  1  write one card into the store
- wr_deck  in  DECK_W  deck written
- wr_addr  in  ADDR_W  card index written
- wr_data  in  CW  card contents
- start  in  1  begin streaming a deck (sampled only in IDLE)
- deck_sel  in  DECK_W  deck to stream, sampled with start
- stop_on_blank  in  1  end the deck at the first all-F card, sampled with start
- abort  in  1  cancel the current stream
- busy  out  1  high in any state other than IDLE
- card_valid  out  1  card_data, card_idx and card_last are valid
- card_ready  in  1  downstream accepts the card
- card_data  out  CW  current card
- card_idx  out  ADDR_W  index of the current card within its deck
- card_last  out  1  current card is index DEPTH-1
- done  out  1  one-cycle pulse: deck finished normally
- err  out  1  one-cycle pulse: start with deck_sel >= NUM_DECKS

## Operation
- Storage: NUM_DECKS*DEPTH words of CW bits.
  - Initial contents are all-F.
  - reset_n does not clear the contents.
  - Writes out of range (wr_deck >= NUM_DECKS or wr_addr >= DEPTH) are ignored.
- Reads are synchronous, one-cycle latency.
  - If a write and a read hit the same word in the same cycle, the read returns the old data.
  - Writes are allowed while busy. A write to a card not yet fetched is seen by the stream.
- FSM states: IDLE, FETCH, PRESENT, BLANK.
  - IDLE: start with deck_sel < NUM_DECKS latches deck, stop_on_blank, idx=0, then goes to FETCH. An invalid deck pulses err and stays in IDLE.
  - FETCH: reads (deck, idx) into the card_data register, then goes to PRESENT.
  - PRESENT: if the latched stop_on_blank is set and card_data == all-F, go to BLANK with card_valid low. Otherwise card_valid=1 and hold until card_ready.
    - On handshake with idx == DEPTH-1: done pulse, go to IDLE.
    - Otherwise: idx+1, go to FETCH.
  - BLANK: done pulse, go to IDLE. The blank card is never presented.
- card_data, card_idx and card_last are stable while card_valid=1 and card_ready=0.
- abort in any non-IDLE state: go to IDLE next cycle, card_valid low, no done.
  - abort has priority over a simultaneous handshake. The card is then considered not consumed.
- start while busy is ignored. err never asserts while busy.
- Mask decks need no separate mode: the producer loads them as ordinary decks, e.g. the X power-of-ten mask 1FFFF.

## Timing
- Reset (reset_n=0 at an edge): state IDLE; busy, card_valid, done, err, card_last = 0; card_data = all-F; card_idx = 0.
- start accepted at cycle t: FETCH at t+1, first card_valid at t+2.
- Handshake at cycle u (not last): FETCH at u+1, next card_valid at u+2. Peak throughput is 1 card per 2 cycles.
- Last-card handshake at u: done=1 and busy=0 at u+1. A new start can be accepted at u+1.
- Blank card: fetched at f, PRESENT (card_valid=0) at f+1, BLANK with done=1 at f+2, IDLE at f+3.
- err is asserted in the cycle after the invalid start, for one cycle.
- card_last = card_valid & (card_idx == DEPTH-1).

## Test plan
- Load deck 0 card 0 = 2535F, rest all-F, DIGITS=5 DEPTH=15. Start deck 0 with stop_on_blank=0 and ready held high -> 15 cards; first is 2535F at t+2, idx 0..14, card_last only on idx 14, done one cycle after the last handshake.
- Same deck with stop_on_blank=1 -> exactly one card (2535F, idx 0, card_last=0), then done at f+2 after the idx-1 fetch; card_valid never asserted for the blank card.
- Backpressure: ready low for 5 cycles on card idx 0 of a deck holding 1234F, 1089F -> card_data/card_idx held stable; on release, 1089F appears 2 cycles after the handshake.
- Start with deck_sel = NUM_DECKS (8, DECK_W=4 build) -> err pulse at t+1; busy stays 0; a start during a stream is ignored with no err.
- Abort while PRESENT on idx 3 with ready=1 in the same cycle -> IDLE next cycle, no done; a new start replays from idx 0.
- Write deck 2 idx 1 = 1089F while streaming deck 2 at idx 0 (before its fetch) -> idx 1 presents 1089F. Reset mid-stream -> all outputs at their reset values next cycle, and deck contents preserved.
